// File: rtl/minmax_serial_sel.sv
// Bit-serial unsigned min/max selector: compares MSB-first, one bit per cycle,
// and returns min, max, a>b and a==b on a valid/ready result port.
module minmax_serial_sel #(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [WIDTH-1:0] out_max,
    output logic             out_a_gt_b,
    output logic             out_eq
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             found_q, found_d, gt_q, gt_d;
    logic [WIDTH-1:0] min_q, min_d, max_q, max_d;
    logic             agtb_q, agtb_d, eq_q, eq_d;
    logic             diff, fin;

    assign in_ready   = (state_q == IDLE) && !rst;
    assign out_valid  = (state_q == DONE);
    assign out_min    = min_q;
    assign out_max    = max_q;
    assign out_a_gt_b = agtb_q;
    assign out_eq     = eq_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        found_d = found_q;
        gt_d    = gt_q;
        min_d   = min_q;
        max_d   = max_q;
        agtb_d  = agtb_q;
        eq_d    = eq_q;
        diff    = a_q[idx_q] ^ b_q[idx_q];
        fin     = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    idx_d   = IW'(WIDTH - 1);
                    found_d = 1'b0;
                    gt_d    = 1'b0;
                    state_d = CMP;
                end
            end
            CMP: begin
                // Only the first (most significant) difference decides the order.
                if (diff && !found_q) begin
                    found_d = 1'b1;
                    gt_d    = a_q[idx_q];
                end
                fin = (EARLY_EXIT && diff && !found_q) || (idx_q == '0);
                if (fin) begin
                    state_d = DONE;
                    agtb_d  = gt_d;
                    eq_d    = !found_d;
                    max_d   = gt_d ? a_q : b_q;
                    min_d   = gt_d ? b_q : a_q;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            found_q <= 1'b0;
            gt_q    <= 1'b0;
            min_q   <= '0;
            max_q   <= '0;
            agtb_q  <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            found_q <= found_d;
            gt_q    <= gt_d;
            min_q   <= min_d;
            max_q   <= max_d;
            agtb_q  <= agtb_d;
            eq_q    <= eq_d;
        end
    end
endmodule

// File: tb/tb_minmax_serial_sel.sv
// Directed and random checks of minmax_serial_sel against a plain arithmetic
// model; instance 1 uses early exit, instance 0 always scans every bit.
module tb_minmax_serial_sel;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic [W-1:0] in_a      [2];
    logic [W-1:0] in_b      [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic [W-1:0] out_min   [2];
    logic [W-1:0] out_max   [2];
    logic         out_a_gt_b[2];
    logic         out_eq    [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    minmax_serial_sel #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0]), .in_b(in_b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_min(out_min[0]), .out_max(out_max[0]), .out_a_gt_b(out_a_gt_b[0]), .out_eq(out_eq[0]));

    minmax_serial_sel #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1]), .in_b(in_b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_min(out_min[1]), .out_max(out_max[1]), .out_a_gt_b(out_a_gt_b[1]), .out_eq(out_eq[1]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference latency: cycles from accept to out_valid, from the bit position rules.
    function automatic int ref_lat(input bit ee, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x;
        x = a ^ b;
        if (!ee || x == '0) return W;
        for (int i = W - 1; i >= 0; i--)
            if (x[i]) return W - i;
        return W;
    endfunction

    // One transaction on instance s; full=1 checks everything, else only the key results.
    task automatic txn(input int s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int stall, input bit full);
        int k;
        logic [W-1:0] emin, emax;
        emin = (a < b) ? a : b;
        emax = (a < b) ? b : a;
        @(negedge clk);
        if (full) chk("in_ready_idle", in_ready[s], 1'b1);
        in_valid[s] = 1'b1;
        in_a[s] = a;
        in_b[s] = b;
        @(posedge clk);
        #1;
        in_valid[s] = 1'b0;
        in_a[s] = ~a;
        in_b[s] = $urandom;
        if (full) chk("in_ready_busy", in_ready[s], 1'b0);
        k = 0;
        while (k < W + 8) begin
            if (k > 0 && out_valid[s]) break;
            @(posedge clk);
            #1;
            k++;
            if (k == 2) begin
                in_valid[s] = 1'b1;
            end
        end
        in_valid[s] = 1'b0;
        chk("latency", 64'(k), 64'(ref_lat(s == 1, a, b)));
        chk("out_valid", out_valid[s], 1'b1);
        chk("out_min", out_min[s], emin);
        chk("out_max", out_max[s], emax);
        chk("out_a_gt_b", out_a_gt_b[s], a > b);
        chk("out_eq", out_eq[s], a == b);
        for (int c = 0; c < stall; c++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", out_valid[s], 1'b1);
            chk("stall_min", out_min[s], emin);
            chk("stall_max", out_max[s], emax);
            chk("stall_in_ready", in_ready[s], 1'b0);
        end
        out_ready[s] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[s] = 1'b0;
        if (full) begin
            chk("post_hs_valid", out_valid[s], 1'b0);
            chk("post_hs_in_ready", in_ready[s], 1'b1);
        end
    endtask

    initial begin
        int k;
        bit seen;
        logic [W-1:0] ra, rb;
        for (int s = 0; s < 2; s++) begin
            in_valid[s] = 1'b0;
            in_a[s] = '0;
            in_b[s] = '0;
            out_ready[s] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("rst_in_ready", in_ready[s], 1'b0);
            chk("rst_out_valid", out_valid[s], 1'b0);
            chk("rst_out_min", out_min[s], '0);
            chk("rst_out_max", out_max[s], '0);
            chk("rst_flags", {out_a_gt_b[s], out_eq[s]}, 2'b00);
        end
        rst = 1'b0;
        #1;
        chk("rel_in_ready", in_ready[1], 1'b1);

        txn(1, 32'd5, 32'd3, 0, 1'b1);
        txn(1, 32'h8000_0000, 32'h7FFF_FFFF, 0, 1'b1);
        txn(1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 1'b1);
        txn(1, 32'd1, 32'd2, 10, 1'b1);
        txn(1, 32'd0, 32'hFFFF_FFFF, 0, 1'b1);
        txn(1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 1'b1);

        // Reset three cycles into CMP abandons the operation.
        @(negedge clk);
        in_valid[1] = 1'b1;
        in_a[1] = 32'd0;
        in_b[1] = 32'h0000_FFFF;
        @(posedge clk);
        #1;
        in_valid[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_in_ready", in_ready[1], 1'b0);
        chk("mid_rst_valid", out_valid[1], 1'b0);
        chk("mid_rst_outs", {out_min[1], out_max[1], out_a_gt_b[1], out_eq[1]}, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("after_rst_in_ready", in_ready[1], 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid[1]) seen = 1'b1;
        end
        chk("no_valid_after_rst", seen, 1'b0);

        txn(0, 32'd0, 32'd0, 0, 1'b1);
        txn(0, 32'hFFFF_FFFF, 32'd0, 0, 1'b1);
        txn(0, 32'h1234_5678, 32'h1234_5678, 2, 1'b1);
        txn(0, 32'd1, 32'd0, 0, 1'b1);
        txn(0, 32'h8000_0001, 32'h8000_0002, 0, 1'b1);

        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            rb = (n % 10 == 0) ? ra : (n % 7 == 0) ? (ra ^ (32'd1 << $urandom_range(31, 0))) : $urandom;
            txn(0, ra, rb, n % 3, 1'b0);
        end
        for (int n = 0; n < 300; n++) begin
            ra = $urandom;
            rb = (n % 2 == 0) ? (ra ^ (32'd1 << $urandom_range(31, 0))) : $urandom;
            txn(1, ra, rb, 0, 1'b0);
        end

        k = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
